// File: rtl/dds_mc.sv
// Multi-channel direct digital synthesiser: CHANNELS phase accumulators share one
// quarter-wave sine table; each sampling_pulse emits one signed sample per channel in order.
module dds_mc #(
    parameter int    CHANNELS = 2,
    parameter int    INT_W    = 12,
    parameter int    FRAC_W   = 10,
    parameter int    SAMPLE_W = 16,
    parameter string LUT_FILE = "sine_q.hex",
    localparam int   CH_W     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1,
    localparam int   ACC_W    = INT_W + FRAC_W
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                k_wr,
    input  logic [CH_W-1:0]     k_ch,
    input  logic [ACC_W-1:0]    k_in,
    input  logic                ofs_wr,
    input  logic [CH_W-1:0]     ofs_ch,
    input  logic [INT_W-1:0]    ofs_in,
    input  logic                sampling_pulse,
    output logic                busy,
    output logic                new_sample_ready,
    output logic [CH_W-1:0]     sample_ch,
    output logic [SAMPLE_W-1:0] sample,
    output logic                frame_done,
    output logic                overrun
);

    localparam int LUT_DEPTH = 2 ** (INT_W - 2);
    localparam int MAG_W     = SAMPLE_W - 1;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;

    // Quarter-wave table generated from its defining formula at elaboration, so it
    // always matches INT_W/SAMPLE_W; LUT_FILE names the equivalent offline image.
    function automatic logic [MAG_W-1:0] lut_entry(input int idx);
        real amp;
        real ang;
        amp = (2.0 ** (SAMPLE_W - 1)) - 1.0;
        ang = 2.0 * 3.14159265358979323846 * (real'(idx) + 0.5) / (2.0 ** INT_W);
        return MAG_W'($rtoi(amp * $sin(ang) + 0.5));
    endfunction

    logic [MAG_W-1:0] lut [LUT_DEPTH];

    for (genvar i = 0; i < LUT_DEPTH; i++) begin : g_lut
        assign lut[i] = lut_entry(i);
    end

    logic [1:0]       state;
    logic [CH_W-1:0]  ch_cnt;
    logic             drain_cnt;
    logic [ACC_W-1:0] acc     [CHANNELS];
    logic [ACC_W-1:0] k_sh    [CHANNELS];
    logic [ACC_W-1:0] k_act   [CHANNELS];
    logic [INT_W-1:0] ofs_sh  [CHANNELS];
    logic [INT_W-1:0] ofs_act [CHANNELS];

    logic             s1_valid;
    logic [CH_W-1:0]  s1_ch;
    logic [INT_W-1:0] s1_p;
    logic             s2_valid;
    logic [CH_W-1:0]  s2_ch;
    logic             s2_neg;
    logic [MAG_W-1:0] s2_mag;
    logic [INT_W-3:0] lut_addr;

    // The last sample of a frame still counts as busy, so a pulse landing on it is refused.
    assign busy = (state != S_IDLE) || new_sample_ready;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= S_IDLE;
            ch_cnt    <= '0;
            drain_cnt <= 1'b0;
            overrun   <= 1'b0;
            // NOTE: the per-channel arrays are small register files holding architectural
            // state, so they are cleared by reset like any other register.
            for (int i = 0; i < CHANNELS; i++) begin
                acc[i]     <= '0;
                k_sh[i]    <= '0;
                k_act[i]   <= '0;
                ofs_sh[i]  <= '0;
                ofs_act[i] <= '0;
            end
        end else begin
            if (sampling_pulse && busy) overrun <= 1'b1;

            for (int i = 0; i < CHANNELS; i++) begin
                if (k_wr && k_ch == CH_W'(i))     k_sh[i]   <= k_in;
                if (ofs_wr && ofs_ch == CH_W'(i)) ofs_sh[i] <= ofs_in;
            end

            case (state)
                S_IDLE: begin
                    if (sampling_pulse && !busy) begin
                        // Same-cycle shadow writes bypass into the frame being latched.
                        for (int i = 0; i < CHANNELS; i++) begin
                            k_act[i]   <= (k_wr && k_ch == CH_W'(i)) ? k_in : k_sh[i];
                            ofs_act[i] <= (ofs_wr && ofs_ch == CH_W'(i)) ? ofs_in : ofs_sh[i];
                        end
                        ch_cnt <= '0;
                        state  <= S_RUN;
                    end
                end
                S_RUN: begin
                    acc[ch_cnt] <= acc[ch_cnt] + k_act[ch_cnt];
                    if (ch_cnt == CH_W'(CHANNELS - 1)) begin
                        state     <= S_DRAIN;
                        drain_cnt <= 1'b0;
                    end else begin
                        ch_cnt <= ch_cnt + CH_W'(1);
                    end
                end
                S_DRAIN: begin
                    if (drain_cnt) state <= S_IDLE;
                    else           drain_cnt <= 1'b1;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Odd quadrants mirror the table address before the read; the sign is applied last.
    assign lut_addr = s1_p[INT_W-2] ? ~s1_p[INT_W-3:0] : s1_p[INT_W-3:0];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_valid         <= 1'b0;
            s1_ch            <= '0;
            s1_p             <= '0;
            s2_valid         <= 1'b0;
            s2_ch            <= '0;
            s2_neg           <= 1'b0;
            s2_mag           <= '0;
            new_sample_ready <= 1'b0;
            frame_done       <= 1'b0;
            sample_ch        <= '0;
            sample           <= '0;
        end else begin
            s1_valid <= (state == S_RUN);
            if (state == S_RUN) begin
                s1_ch <= ch_cnt;
                s1_p  <= acc[ch_cnt][ACC_W-1:FRAC_W] + ofs_act[ch_cnt];
            end

            s2_valid <= s1_valid;
            s2_ch    <= s1_ch;
            s2_neg   <= s1_p[INT_W-1];
            s2_mag   <= lut[lut_addr];

            new_sample_ready <= s2_valid;
            frame_done       <= s2_valid && (s2_ch == CH_W'(CHANNELS - 1));
            if (s2_valid) begin
                sample_ch <= s2_ch;
                sample    <= s2_neg ? SAMPLE_W'(0) - {1'b0, s2_mag} : {1'b0, s2_mag};
            end
        end
    end

endmodule
